// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store requesters with a single transaction in flight.
// Data wins ties unless fetch has already lost STARVE_MAX consecutive grants; responses cannot be stalled.
module mem_port_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [31:0]       if_addr,
    output logic              if_resp_valid,
    output logic [31:0]       if_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_resp_valid,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [2:0] WAIT_INIT  = 3'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic [2:0]        wait_q, wait_d;
    logic              owner_q, owner_d;      // 1 = data requester owns the transaction
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              grant_data;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    // Fetch takes a tie only once its starvation budget is exhausted.
    assign grant_data   = d_req_valid && !(if_req_valid && (starve_q == STARVE_LIM));
    assign d_req_ready  = !rst && (state_q == IDLE) && grant_data;
    assign if_req_ready = !rst && (state_q == IDLE) && if_req_valid && !grant_data;

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        wait_d        = wait_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        mem_we        = 1'b0;
        if_resp_valid = 1'b0;
        d_resp_valid  = 1'b0;
        busy          = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (!if_req_valid) begin
                    starve_d = '0;
                end
                if (d_req_ready) begin
                    owner_d = 1'b1;
                    addr_d  = d_addr[ADDR_W+1:2];
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    state_d = ISSUE;
                    if (if_req_valid && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (if_req_ready) begin
                    owner_d  = 1'b0;
                    addr_d   = if_addr[ADDR_W+1:2];
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    starve_d = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                mem_we = we_q;
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    wait_d  = WAIT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wait_q == 3'd0) begin
                    if (owner_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            RESP: begin
                if (owner_q) begin
                    d_resp_valid = 1'b1;
                end else begin
                    if_resp_valid = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            wait_q     <= '0;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiter instances (MEM_LAT=1 and MEM_LAT=3) against small memory models.
module tb_mem_port_arbiter;

    localparam int BUDGET = 40;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // instance A: MEM_LAT=1
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_resp_valid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [5:0]  mem_addr;
    logic        mem_we, busy;
    logic [31:0] mem_wdata, mem_rdata;

    // instance B: MEM_LAT=3
    logic        b_if_req_valid, b_if_req_ready, b_if_resp_valid;
    logic [31:0] b_if_addr, b_if_rdata;
    logic        b_d_req_valid, b_d_req_ready, b_d_we, b_d_resp_valid;
    logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
    logic [5:0]  b_mem_addr;
    logic        b_mem_we, b_busy;
    logic [31:0] b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.ADDR_W(6), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(6), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .rst(rst),
        .if_req_valid(b_if_req_valid), .if_req_ready(b_if_req_ready), .if_addr(b_if_addr),
        .if_resp_valid(b_if_resp_valid), .if_rdata(b_if_rdata),
        .d_req_valid(b_d_req_valid), .d_req_ready(b_d_req_ready), .d_we(b_d_we),
        .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_resp_valid(b_d_resp_valid), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .busy(b_busy)
    );

    // Memory models: mem[i] = 0x1000_0000+i except mem[2]; mem2[i] = 0x2000_0000+i except mem2[15].
    logic [31:0] mem [64];
    logic [31:0] rd_a;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem[2] <= 32'hDEAD_BEEF;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd_a <= mem[mem_addr];
    end
    assign mem_rdata = rd_a;

    logic [31:0] mem2 [64];
    logic [31:0] pipe_b [3];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem2[i] <= 32'h2000_0000 + 32'(i);
            mem2[15] <= 32'hCAFE_F00D;
        end else if (b_mem_we) begin
            mem2[b_mem_addr] <= b_mem_wdata;
        end
        pipe_b[0] <= mem2[b_mem_addr];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign b_mem_rdata = pipe_b[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string msg);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, msg);
    endtask

    exp_t if_q[$];
    exp_t d_q[$];
    exp_t b_q[$];
    logic glog[$];
    int   we_cnt = 0, b_we_cnt = 0;
    logic [5:0]  last_we_addr;
    logic [31:0] last_we_data;

    always @(negedge clk) begin
        exp_t e;
        if (if_req_ready || d_req_ready)
            check("ready_exclusive", 32'(if_req_ready & d_req_ready), 32'd0);
        if (if_req_valid && if_req_ready) glog.push_back(1'b1);
        if (d_req_valid && d_req_ready)   glog.push_back(1'b0);
        if (mem_we) begin
            we_cnt++;
            last_we_addr = mem_addr;
            last_we_data = mem_wdata;
        end
        if (b_mem_we) b_we_cnt++;
        if (if_resp_valid) begin
            if (if_q.size() == 0) fail("if_resp_unexpected", "got if_resp_valid=1, expected 0");
            else begin
                e = if_q.pop_front();
                check("if_rdata", if_rdata, e.data);
                check("if_resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (d_resp_valid) begin
            if (d_q.size() == 0) fail("d_resp_unexpected", "got d_resp_valid=1, expected 0");
            else begin
                e = d_q.pop_front();
                check("d_rdata", d_rdata, e.data);
                check("d_resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (b_if_resp_valid) fail("b_if_resp_unexpected", "got if_resp_valid=1, expected 0");
        if (b_d_resp_valid) begin
            if (b_q.size() == 0) fail("b_d_resp_unexpected", "got d_resp_valid=1, expected 0");
            else begin
                e = b_q.pop_front();
                check("b_d_rdata", b_d_rdata, e.data);
                check("b_d_resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // All drivers start and end at posedge+1.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic if_req(input logic [31:0] a, input logic [31:0] exp,
                          output int waited, output int acc);
        exp_t e;
        if_req_valid = 1'b1;
        if_addr      = a;
        waited       = 0;
        acc          = -1;
        @(negedge clk);
        while (!if_req_ready && waited < BUDGET) begin
            @(negedge clk);
            waited++;
        end
        if (!if_req_ready) begin
            fail("if_accept_timeout", "if_req_ready never rose within budget");
            if_req_valid = 1'b0;
            step(1);
            return;
        end
        acc    = cyc;
        e.data = exp;
        e.cyc  = acc + 3;
        if_q.push_back(e);
        step(1);
        if_req_valid = 1'b0;
        check("if_issue_mem_addr", 32'(mem_addr), 32'(a[7:2]));
        check("if_issue_mem_we", 32'(mem_we), 32'd0);
    endtask

    task automatic d_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp, output int waited, output int acc);
        exp_t e;
        d_req_valid = 1'b1;
        d_we        = we;
        d_addr      = a;
        d_wdata     = wd;
        waited      = 0;
        acc         = -1;
        @(negedge clk);
        while (!d_req_ready && waited < BUDGET) begin
            @(negedge clk);
            waited++;
        end
        if (!d_req_ready) begin
            fail("d_accept_timeout", "d_req_ready never rose within budget");
            d_req_valid = 1'b0;
            step(1);
            return;
        end
        acc    = cyc;
        e.data = exp;
        e.cyc  = acc + (we ? 2 : 3);
        d_q.push_back(e);
        step(1);
        d_req_valid = 1'b0;
        check("d_issue_mem_addr", 32'(mem_addr), 32'(a[7:2]));
        check("d_issue_mem_we", 32'(mem_we), 32'(we));
        if (we) check("d_issue_mem_wdata", mem_wdata, wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w1, w2, a1, a2, we0, bw;
        exp_t e;
        logic [10:0] gv;

        rst = 1'b1;
        if_req_valid = 1'b1; if_addr = 32'h0; d_req_valid = 1'b1; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0;
        b_if_req_valid = 1'b0; b_if_addr = 32'h0; b_d_req_valid = 1'b0; b_d_we = 1'b0;
        b_d_addr = 32'h0; b_d_wdata = 32'h0;
        step(3);
        check("rst_if_ready_gated", 32'(if_req_ready), 32'd0);
        check("rst_d_ready_gated", 32'(d_req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_resp_valid", 32'({if_resp_valid, d_resp_valid}), 32'd0);
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        rst = 1'b0;
        step(2);

        // plain fetch read
        if_req(32'h08, 32'hDEAD_BEEF, w1, a1);
        check("fetch_wait", 32'(w1), 32'd0);
        step(5);

        // simultaneous requests: data first, fetch in the first IDLE after d_resp
        fork
            d_req(1'b0, 32'h0, 32'h0, 32'h1000_0000, w1, a1);
            if_req(32'h4, 32'h1000_0001, w2, a2);
        join
        check("tie_data_first_wait", 32'(w1), 32'd0);
        check("tie_fetch_accept_gap", 32'(a2 - a1), 32'd4);
        step(5);

        // store then fetch of the same word
        we0 = we_cnt;
        d_req(1'b1, 32'h14, 32'h1234_5678, 32'h1000_0000, w1, a1);
        step(4);
        check("store_we_pulses", 32'(we_cnt - we0), 32'd1);
        check("store_we_addr", 32'(last_we_addr), 32'd5);
        check("store_we_data", last_we_data, 32'h1234_5678);
        check("store_d_rdata_kept", d_rdata, 32'h1000_0000);
        if_req(32'h14, 32'h1234_5678, w1, a1);
        step(5);

        // starvation bound with continuous data traffic
        glog.delete();
        fork
            begin
                repeat (9) d_req(1'b0, 32'h20, 32'h0, 32'h1000_0008, w1, a1);
            end
            begin
                repeat (2) if_req(32'h24, 32'h1000_0009, w2, a2);
            end
        join
        step(6);
        check("starve_grant_count", 32'(glog.size()), 32'd11);
        gv = '0;
        foreach (glog[i]) if (i < 11) gv[10-i] = glog[i];
        check("starve_grant_order", 32'(gv), 32'(11'b00001000010));

        // address wrap and misalignment
        d_req(1'b0, 32'h10B, 32'h0, 32'hDEAD_BEEF, w1, a1);
        step(5);
        if_req(32'hFFFF_FF17, 32'h1234_5678, w1, a1);
        step(5);

        // reset while a fetch is in WAIT
        if_addr = 32'h08;
        if_req_valid = 1'b1;
        w1 = 0;
        @(negedge clk);
        while (!if_req_ready && w1 < BUDGET) begin
            @(negedge clk);
            w1++;
        end
        if (!if_req_ready) fail("rst_fetch_accept_timeout", "if_req_ready never rose within budget");
        step(1);
        if_req_valid = 1'b0;
        step(1);
        check("wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_if_rdata", if_rdata, 32'd0);
        check("midrst_d_rdata", d_rdata, 32'd0);
        if_req(32'h08, 32'hDEAD_BEEF, w1, a1);
        check("midrst_rereq_wait", 32'(w1), 32'd0);
        step(6);

        // MEM_LAT=3 load on instance B
        b_d_addr = 32'h3C;
        b_d_req_valid = 1'b1;
        bw = 0;
        @(negedge clk);
        while (!b_d_req_ready && bw < BUDGET) begin
            @(negedge clk);
            bw++;
        end
        if (!b_d_req_ready) begin
            fail("b_accept_timeout", "b d_req_ready never rose within budget");
        end else begin
            e.data = 32'hCAFE_F00D;
            e.cyc  = cyc + 5;
            b_q.push_back(e);
        end
        step(1);
        b_d_req_valid = 1'b0;
        step(10);

        check("b_mem_we_count", 32'(b_we_cnt), 32'd0);
        check("if_q_drained", 32'(if_q.size()), 32'd0);
        check("d_q_drained", 32'(d_q.size()), 32'd0);
        check("b_q_drained", 32'(b_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
